// File: rtl/tx_framer_if.sv
// Byte-stream bundle between a producer, the framer and the downstream sink.
// master = producer side (drives payload, observes framed output); slave = framer.
interface tx_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_d;
  logic       out_valid;
  logic       err_trunc;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, out_d, out_valid, err_trunc
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, out_d, out_valid, err_trunc
  );
endinterface

// File: rtl/tx_framer.sv
// Store-and-forward framer: buffers a payload, then emits SYNC, LEN, payload, XOR checksum.
// Output bytes are registered; each is computed from the state being entered.
module tx_framer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic        clk,
  input logic        reset_n,
  tx_framer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {LOAD, SYNC, LEN, PAY, CHK} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [CW-1:0] rd_ptr, rd_ptr_nx;
  logic [7:0]    chk, chk_nx;
  logic [7:0]    out_d_nx;
  logic          out_valid_nx;
  logic          err_nx;
  logic          accept;
  logic          at_full;
  logic [7:0]    len_byte;
  logic [7:0]    mem [DEPTH];

  // Gated by reset_n so the producer sees not-ready throughout reset.
  assign bus.in_ready = (state == LOAD) && reset_n;
  assign accept       = bus.in_valid && bus.in_ready;
  assign at_full      = (count == CW'(DEPTH - 1));
  assign len_byte     = 8'(count);

  always_comb begin
    state_nx     = state;
    count_nx     = count;
    rd_ptr_nx    = rd_ptr;
    chk_nx       = chk;
    out_d_nx     = 8'h00;
    out_valid_nx = 1'b0;
    err_nx       = 1'b0;
    unique case (state)
      LOAD: begin
        if (accept) begin
          count_nx = count + CW'(1);
          chk_nx   = chk ^ bus.in_data;
          // A full buffer closes the frame even without in_last.
          if (bus.in_last || at_full) begin
            state_nx     = SYNC;
            out_d_nx     = SYNC_BYTE;
            out_valid_nx = 1'b1;
            err_nx       = !bus.in_last;
          end
        end
      end
      SYNC: begin
        state_nx     = LEN;
        out_d_nx     = len_byte;
        out_valid_nx = 1'b1;
      end
      LEN: begin
        state_nx     = PAY;
        out_d_nx     = mem[0];
        rd_ptr_nx    = CW'(1);
        out_valid_nx = 1'b1;
      end
      PAY: begin
        out_valid_nx = 1'b1;
        if (rd_ptr == count) begin
          state_nx = CHK;
          out_d_nx = chk;
        end else begin
          out_d_nx  = mem[rd_ptr[AW-1:0]];
          rd_ptr_nx = rd_ptr + CW'(1);
        end
      end
      CHK: begin
        state_nx  = LOAD;
        count_nx  = '0;
        chk_nx    = 8'h00;
        rd_ptr_nx = '0;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= LOAD;
      count         <= '0;
      rd_ptr        <= '0;
      chk           <= 8'h00;
      bus.out_d     <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.err_trunc <= 1'b0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      rd_ptr        <= rd_ptr_nx;
      chk           <= chk_nx;
      bus.out_d     <= out_d_nx;
      bus.out_valid <= out_valid_nx;
      bus.err_trunc <= err_nx;
    end
  end

  // Payload storage needs no reset; stale bytes are never read past count.
  always_ff @(posedge clk) begin
    if (accept) mem[count[AW-1:0]] <= bus.in_data;
  end
endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: expected frame bytes and frame lengths are queued
// as payloads are loaded, and checked against the output stream as it appears.
module tb_tx_framer;
  logic clk = 1'b0;
  logic reset_n;

  tx_framer_if bus ();

  tx_framer #(.DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         len_q[$];
  logic [7:0] fr[$];
  int         run = 0;
  int         trunc_pulses = 0;
  logic [7:0] mon_e;
  int         mon_len;

  // Output monitor: every valid byte against the scoreboard, idle bus must be 00,
  // and each out_valid burst length against the queued L+3.
  always @(negedge clk) begin
    if (!reset_n) begin
      run = 0;
    end else if (bus.out_valid) begin
      run++;
      mon_e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      assert (bus.out_d === mon_e)
        else begin errors++; $error("FAIL out_byte got %02h expected %02h", bus.out_d, mon_e); end
    end else begin
      checks++;
      assert (bus.out_d === 8'h00)
        else begin errors++; $error("FAIL idle_d got %02h expected 00", bus.out_d); end
      if (run != 0) begin
        mon_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
        checks++;
        assert (run === mon_len)
          else begin errors++; $error("FAIL burst_len got %0d expected %0d", run, mon_len); end
        run = 0;
      end
    end
    if (reset_n && bus.err_trunc) trunc_pulses++;
  end

  task automatic push_frame(input logic [7:0] p[$]);
    logic [7:0] x = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(p.size()));
    foreach (p[i]) begin
      exp_q.push_back(p[i]);
      x ^= p[i];
    end
    exp_q.push_back(x);
    len_q.push_back(p.size() + 3);
  endtask

  // Idle cycles carry random data and in_last so ignored inputs are exercised.
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_last  = 1'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 100)
      else begin errors++; $error("FAIL ready_timeout got %0d expected <100", n); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic load_frame(input int gapmax);
    foreach (fr[i]) send(fr[i], 1'(i == fr.size() - 1), int'($urandom_range(gapmax, 0)));
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++;
    assert (exp_q.size() == 0)
      else begin errors++; $error("FAIL drain got %0d expected 0", exp_q.size()); end
    checks++;
    assert (bus.in_ready === 1'b1)
      else begin errors++; $error("FAIL ready_after got %b expected 1", bus.in_ready); end
    checks++;
    assert (bus.out_valid === 1'b0)
      else begin errors++; $error("FAIL valid_after got %b expected 0", bus.out_valid); end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want)
      else begin errors++; $error("FAIL %s got %b expected %b", tag, got, want); end
  endtask

  initial begin
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    #1;
    chk_bit("rst_valid", bus.out_valid, 1'b0);
    chk_bit("rst_ready", bus.in_ready, 1'b0);
    chk_bit("rst_trunc", bus.err_trunc, 1'b0);
    checks++;
    assert (bus.out_d === 8'h00)
      else begin errors++; $error("FAIL rst_d got %02h expected 00", bus.out_d); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1 chk_bit("ready_release", bus.in_ready, 1'b1);

    // Three-byte frame
    fr = {8'h11, 8'h22, 8'h33};
    push_frame(fr);
    load_frame(0);
    wait_done();

    // Single-byte frame
    fr = {8'h5A};
    push_frame(fr);
    load_frame(0);
    wait_done();

    // Truncation at DEPTH; the 17th byte opens the next frame
    fr = {};
    for (int i = 0; i < 16; i++) fr.push_back(8'(i));
    push_frame(fr);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 0);
    @(negedge clk);
    chk_bit("trunc_pulse", bus.err_trunc, 1'b1);
    @(negedge clk);
    chk_bit("trunc_clear", bus.err_trunc, 1'b0);
    fr = {8'h10, 8'h20};
    push_frame(fr);
    load_frame(0);
    wait_done();

    // Random in_valid gaps during load
    fr = {8'h01, 8'h02, 8'h04, 8'h08};
    push_frame(fr);
    load_frame(3);
    wait_done();

    // Reset in the middle of PAY
    fr = {8'h01, 8'h02, 8'h03, 8'h04};
    push_frame(fr);
    load_frame(0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_bit("midrst_valid", bus.out_valid, 1'b0);
    chk_bit("midrst_ready", bus.in_ready, 1'b0);
    checks++;
    assert (bus.out_d === 8'h00)
      else begin errors++; $error("FAIL midrst_d got %02h expected 00", bus.out_d); end
    exp_q.delete();
    len_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk_bit("midrst_release", bus.in_ready, 1'b1);
    fr = {8'h7E, 8'h81};
    push_frame(fr);
    load_frame(0);
    wait_done();

    // Back-to-back frames
    fr = {8'hAA};
    push_frame(fr);
    fr = {8'hBB, 8'hCC};
    push_frame(fr);
    send(8'hAA, 1'b1, 0);
    send(8'hBB, 1'b0, 0);
    send(8'hCC, 1'b1, 0);
    wait_done();

    checks++;
    assert (trunc_pulses === 1)
      else begin errors++; $error("FAIL trunc_count got %0d expected 1", trunc_pulses); end
    checks++;
    assert (len_q.size() == 0)
      else begin errors++; $error("FAIL bursts_left got %0d expected 0", len_q.size()); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tx_framer.md
TX_FRAMER -- requirements
Module: tx_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning maximum payload bytes per frame (power of two, 2..256).
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning frame start marker.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_data  input  8  payload byte from the producer.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_last  input  1  qualifies the final payload byte of a frame.
REQ-008 SHALL have port in_ready  output  1  framer accepts a byte this cycle.
REQ-009 SHALL have port out_d  output  8  framed byte stream toward the downstream d input of the DUT.
REQ-010 SHALL have port out_valid  output  1  out_d carries a frame byte.
REQ-011 SHALL have port err_trunc  output  1  one-cycle pulse: frame truncated at DEPTH bytes.

Function
REQ-012 SHALL implement states LOAD, SYNC, LEN, PAY, CHK; LOAD is the reset state.
REQ-013 SHALL drive in_ready=1 only in LOAD; a byte is accepted on an edge where in_valid && in_ready.
REQ-014 SHALL store accepted bytes in an internal DEPTH-entry buffer at increasing addresses from 0 and count them (count width log2(DEPTH)+1).
REQ-015 SHALL accumulate CHK = XOR of all accepted payload bytes, cleared at frame start.
REQ-016 SHALL, on the edge accepting a byte with in_last=1, move to SYNC.
REQ-017 SHALL, on the edge accepting the DEPTH-th byte with in_last=0, treat it as last, move to SYNC, and pulse err_trunc high for the following cycle.
REQ-018 SHALL ignore in_data/in_last when in_valid=0 or in_ready=0 (no state, count or CHK change).
REQ-019 SHALL register out_d/out_valid; in SYNC out_d=SYNC_BYTE, in LEN out_d=count[7:0] (DEPTH=256 yields 8'h00), in PAY out_d=buffer bytes in acceptance order, in CHK out_d=CHK.
REQ-020 SHALL hold out_valid=1 for exactly L+3 consecutive cycles per frame (L=payload length), first cycle immediately after the last-byte edge; no backpressure.
REQ-021 SHALL drive out_valid=0 and out_d=8'h00 in LOAD.
REQ-022 SHALL return from CHK to LOAD after one cycle, with count and CHK cleared, so in_ready=1 in the cycle after the CHK byte.
REQ-023 SHALL produce frames back-to-back with no other gap than the LOAD phase; zero-length frames cannot occur.

Reset
REQ-024 SHALL, on reset_n low at any time including mid-frame, immediately force state=LOAD, in_ready=1 after release, out_valid=0, out_d=8'h00, err_trunc=0, count=0, CHK=0.
REQ-025 SHALL discard any partially loaded or partially transmitted frame on reset; buffer contents need not be cleared.
REQ-026 SHALL hold in_ready=0 while reset_n is low.

Verification
REQ-027 Bench SHALL send bytes 11,22,33 (last on 33) -> out_d sequence A5,03,11,22,33,00 with out_valid high 6 cycles, then in_ready=1.
REQ-028 Bench SHALL send a single byte 5A with last -> A5,01,5A,5A; out_valid high 4 cycles.
REQ-029 Bench SHALL send 17 bytes 00..10 without last (DEPTH=16) -> frame A5,10,00..0F,00 (XOR 00..0F=00), err_trunc one pulse, byte 10 accepted as first byte of next frame.
REQ-030 Bench SHALL toggle in_valid randomly during load of 4 bytes 01,02,04,08 -> A5,04,01,02,04,08,0F; gaps do not alter output.
REQ-031 Bench SHALL assert reset_n=0 during PAY of a frame -> out_valid=0 asynchronously; after release a new 2-byte frame 7E,81 yields A5,02,7E,81,FF.
REQ-032 Bench SHALL send two frames back-to-back (AA last; BB,CC last) -> A5,01,AA,AA then A5,02,BB,CC,77 with no corrupted bytes.
